ahb_tdes_slave_if: RTL and testbench
====================================

Name: ahb_tdes_slave_if

Overview:
AHB-Lite slave front end for the Triple-DES datapath. It decodes the pipelined AHB address and data phases and holds the mode bit and the three 64-bit keys. A write of a 64-bit data block launches the 3DES core, and the block captures the core result for readback. It sits between the bus master and the 3DES round/core logic inside TopLevel, directly upstream of the core.

Parameters:
BASE_ADDR, 32'hAAAAAAA0, base of the register window; registers sit at BASE_ADDR+0..+6 (byte-granular offsets).
DATA_W, 64, bus and block width; fixed at 64 for DES.

Ports:
HCLK  in  1  bus clock
HRESET  in  1  asynchronous active-low reset
HSEL  in  1  slave select
HADDR  in  32  address (address phase)
HTRANS  in  2  transfer type
HWRITE  in  1  write/read (address phase)
HSIZE  in  3  transfer size; only 3'b011 is legal
HREADY  in  1  bus-wide ready (previous transfer complete)
HWDATA  in  64  write data (data phase)
HRDATA  out  64  read data
HREADYOUT  out  1  this slave's ready
HRESP  out  1  0=OKAY, 1=ERROR
core_start  out  1  one-cycle launch pulse to the core
core_enc  out  1  1=encrypt, 0=decrypt
core_key1/2/3  out  64 each  key registers
core_data  out  64  input block register
core_done  in  1  one-cycle completion pulse from the core
core_result  in  64  core output, valid when core_done=1

Behaviour:
- Reset (HRESET=0, async): HRDATA=0, HREADYOUT=1, HRESP=0, core_start=0, core_enc=0, keys=0, core_data=0, busy=0, valid=0, result=0, FSM=IDLE.
- Address phase accepted when HSEL & HREADY & HREADYOUT (qualification with HTRANS: see Optional Feature). Latch offset=HADDR-BASE_ADDR and HWRITE. Any address outside BASE_ADDR..+6 is not selected and gives an OKAY no-op.
- Register map by offset:
  - 0 MODE: W, bit0 only.
  - 1/2/3 KEY1/2/3: W.
  - 4 DATA: W, launches the core.
  - 5 RESULT: R only.
  - 6 STATUS: R only, {62'b0, valid, busy}.
  - Reads of offsets 0-4 return the register contents.
- Writes: the register loads HWDATA at the end of the data phase, i.e. one cycle after the address phase.
- DATA write when busy=0:
  - core_data loads HWDATA.
  - core_start=1 on the next cycle only.
  - busy=1 from that same cycle.
  - valid is cleared.
- DATA write when busy=1:
  - Data phase stalls: HREADYOUT=0 until the cycle after core_done.
  - Then core_data loads HWDATA (held from the stalled phase), core_start pulses, and HREADYOUT returns to 1.
- MODE/KEY write while busy: accepted with no stall; takes effect on the next launch. The core samples its inputs only on core_start.
- core_done: result loads core_result, busy=0, valid=1. If core_done arrives in the same cycle as a DATA data phase that is not stalled, the write is treated as busy=0.
- Read of RESULT clears valid at the end of the data phase. HRDATA is driven combinationally from the registered offset during the data phase and is 0 otherwise.
- Write to offset 5 or 6: two-cycle ERROR response.
  - Cycle 1: HREADYOUT=0, HRESP=1.
  - Cycle 2: HREADYOUT=1, HRESP=1.
  - No register changes.
- HSIZE != 3'b011 on a mapped access: the same ERROR response.
- FSM states and transitions:
  - IDLE -> DPHASE on an accepted transfer.
  - DPHASE -> STALL (DATA write with busy=1).
  - DPHASE -> ERR1 (illegal access).
  - DPHASE -> IDLE or DPHASE (back-to-back transfer).
  - STALL -> DPHASE_DONE on core_done.
  - ERR1 -> ERR2 -> IDLE.
  - A new address phase is accepted in DPHASE only when HREADYOUT=1.
- Reset mid-operation: all state is cleared. An in-flight core_done after reset is ignored because busy=0.

Optional Feature:
HTRANS_QUAL_EN
- Defined: transfers are accepted only when HTRANS[1]=1 (NONSEQ/SEQ); IDLE/BUSY get OKAY with no effect.
- Undefined: HTRANS is ignored and accepted = HSEL & HREADY & HREADYOUT. Masters that leave HTRANS=00 still work.

Test Plan:
- Reset with HRESET=0 mid-transfer -> all outputs at reset values immediately; STATUS read after release = 0.
- Write MODE=1, KEY1=64'h1111111111111111, KEY2=64'h2222222222222222, KEY3=64'h3333333333333333, DATA=64'h1234567890ABCDEF at consecutive cycles -> core_enc=1, keys match, core_data=64'h1234567890ABCDEF, core_start pulses exactly once on the cycle after the DATA data phase.
- Drive core_done with core_result=64'hDEADBEEFCAFEF00D -> STATUS=2'b10; RESULT read returns 64'hDEADBEEFCAFEF00D; following STATUS read=2'b00.
- Write DATA=64'h4444444444444444 while busy, core_done 10 cycles later -> HREADYOUT low for 10 cycles; second core_start one cycle after core_done; core_data=64'h4444444444444444.
- Write to BASE_ADDR+5 -> HREADYOUT=0,HRESP=1 then HREADYOUT=1,HRESP=1; RESULT unchanged. Write with HSIZE=3'b010 -> same ERROR response.
- HTRANS=00 with HSEL=1, DATA write of 64'h5555555555555555 -> launch occurs with HTRANS_QUAL_EN undefined, no launch with it defined.

Source files
------------

// File: rtl/ahb_tdes_slave_if_if.sv
// AHB-Lite bus bundle for the 3DES slave front end.
// Master drives address/control/write data; slave returns read data and response.
interface ahb_tdes_slave_if_if #(
  parameter int DATA_W = 64
);
  logic              HSEL;
  logic [31:0]       HADDR;
  logic [1:0]        HTRANS;
  logic              HWRITE;
  logic [2:0]        HSIZE;
  logic              HREADY;
  logic [DATA_W-1:0] HWDATA;
  logic [DATA_W-1:0] HRDATA;
  logic              HREADYOUT;
  logic              HRESP;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE,
    output HSIZE, HREADY, HWDATA,
    input  HRDATA, HREADYOUT, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE,
    input  HSIZE, HREADY, HWDATA,
    output HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/ahb_tdes_slave_if.sv
// AHB-Lite slave holding 3DES mode/keys/block; launches the core, captures result.
// HTRANS_QUAL_EN: when defined, only NONSEQ/SEQ transfers are accepted.
module ahb_tdes_slave_if #(
  parameter logic [31:0] BASE_ADDR = 32'hAAAAAAA0,
  parameter int          DATA_W    = 64
) (
  input  logic              HCLK,
  input  logic              HRESET,
  ahb_tdes_slave_if_if.slave bus,
  output logic              core_start,
  output logic              core_enc,
  output logic [DATA_W-1:0] core_key1,
  output logic [DATA_W-1:0] core_key2,
  output logic [DATA_W-1:0] core_key3,
  output logic [DATA_W-1:0] core_data,
  input  logic              core_done,
  input  logic [DATA_W-1:0] core_result
);

  typedef enum logic [2:0] {
    S_IDLE, S_DPHASE, S_STALL,
    S_DDONE, S_ERR1, S_ERR2
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        off_q, off_d;
  logic              wr_q, wr_d;
  logic              enc_q, enc_d;
  logic [DATA_W-1:0] key1_q, key1_d;
  logic [DATA_W-1:0] key2_q, key2_d;
  logic [DATA_W-1:0] key3_q, key3_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              busy_q, busy_d;
  logic              valid_q, valid_d;
  logic              start_q, start_d;

  logic [31:0]       off_full;
  logic              mapped;
  logic              sel;
  logic              accept;
  logic              illegal;
  logic              dphase;
  logic              launch;
  logic              hready;
  logic              hresp;
  logic [DATA_W-1:0] rdata;
  logic              unused_htrans;

  assign off_full = bus.HADDR - BASE_ADDR;
  assign mapped   = off_full < 32'd7;
  assign unused_htrans = ^bus.HTRANS;

`ifdef HTRANS_QUAL_EN
  assign sel = bus.HSEL & bus.HTRANS[1];
`else
  assign sel = bus.HSEL;
`endif

  assign accept  = sel & bus.HREADY & hready & mapped;
  assign illegal = (bus.HWRITE & (off_full[2:0] == 3'd5 |
                                  off_full[2:0] == 3'd6)) |
                   (bus.HSIZE != 3'b011);
  assign dphase  = state_q == S_DPHASE;

  always_comb begin
    state_d  = state_q;
    off_d    = off_q;
    wr_d     = wr_q;
    enc_d    = enc_q;
    key1_d   = key1_q;
    key2_d   = key2_q;
    key3_d   = key3_q;
    data_d   = data_q;
    result_d = result_q;
    busy_d   = busy_q;
    valid_d  = valid_q;
    start_d  = 1'b0;
    launch   = 1'b0;
    hready   = 1'b1;
    hresp    = 1'b0;
    rdata    = '0;

    unique case (state_q)
      S_DPHASE: begin
        // DATA write against a busy core holds the bus until done
        if (wr_q && off_q == 3'd4 && busy_q && !core_done)
          hready = 1'b0;
      end
      S_STALL: hready = 1'b0;
      S_ERR1: begin
        hready = 1'b0;
        hresp  = 1'b1;
      end
      S_ERR2: hresp = 1'b1;
      default: ;
    endcase

    if (dphase && wr_q && hready) begin
      case (off_q)
        3'd0: enc_d  = bus.HWDATA[0];
        3'd1: key1_d = bus.HWDATA;
        3'd2: key2_d = bus.HWDATA;
        3'd3: key3_d = bus.HWDATA;
        3'd4: launch = 1'b1;
        default: ;
      endcase
    end

    if (state_q == S_STALL && core_done)
      launch = 1'b1;

    if (dphase && !wr_q) begin
      case (off_q)
        3'd0: rdata = {{(DATA_W-1){1'b0}}, enc_q};
        3'd1: rdata = key1_q;
        3'd2: rdata = key2_q;
        3'd3: rdata = key3_q;
        3'd4: rdata = data_q;
        3'd5: rdata = result_q;
        3'd6: rdata = {{(DATA_W-2){1'b0}}, valid_q, busy_q};
        default: rdata = '0;
      endcase
      if (off_q == 3'd5)
        valid_d = 1'b0;
    end

    if (busy_q && core_done) begin
      result_d = core_result;
      busy_d   = 1'b0;
      valid_d  = 1'b1;
    end

    if (launch) begin
      data_d  = bus.HWDATA;
      start_d = 1'b1;
      busy_d  = 1'b1;
      valid_d = 1'b0;
    end

    if (dphase && !hready)
      state_d = S_STALL;
    else if (state_q == S_STALL)
      state_d = core_done ? S_DDONE : S_STALL;
    else if (state_q == S_ERR1)
      state_d = S_ERR2;
    else if (accept) begin
      state_d = illegal ? S_ERR1 : S_DPHASE;
      off_d   = off_full[2:0];
      wr_d    = bus.HWRITE;
    end else
      state_d = S_IDLE;
  end

  always_ff @(posedge HCLK or negedge HRESET) begin
    if (!HRESET) begin
      state_q  <= S_IDLE;
      off_q    <= '0;
      wr_q     <= 1'b0;
      enc_q    <= 1'b0;
      key1_q   <= '0;
      key2_q   <= '0;
      key3_q   <= '0;
      data_q   <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      start_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      off_q    <= off_d;
      wr_q     <= wr_d;
      enc_q    <= enc_d;
      key1_q   <= key1_d;
      key2_q   <= key2_d;
      key3_q   <= key3_d;
      data_q   <= data_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
      start_q  <= start_d;
    end
  end

  assign bus.HRDATA    = rdata;
  assign bus.HREADYOUT = hready;
  assign bus.HRESP     = hresp;
  assign core_start    = start_q;
  assign core_enc      = enc_q;
  assign core_key1     = key1_q;
  assign core_key2     = key2_q;
  assign core_key3     = key3_q;
  assign core_data     = data_q;

endmodule

// File: tb/tb_ahb_tdes_slave_if.sv
// Scoreboard bench for ahb_tdes_slave_if: stimulus queues expectations,
// a negedge monitor checks read data, core launches and error responses.
module tb_ahb_tdes_slave_if;
  localparam logic [31:0] BASE = 32'hAAAAAAA0;

  logic        HCLK   = 1'b0;
  logic        HRESET = 1'b1;
  logic        core_start, core_enc;
  logic        core_done = 1'b0;
  logic [63:0] core_key1, core_key2, core_key3;
  logic [63:0] core_data;
  logic [63:0] core_result = '0;

  ahb_tdes_slave_if_if bus ();
  assign bus.HREADY = bus.HREADYOUT;

  ahb_tdes_slave_if dut (
    .HCLK        (HCLK),
    .HRESET      (HRESET),
    .bus         (bus),
    .core_start  (core_start),
    .core_enc    (core_enc),
    .core_key1   (core_key1),
    .core_key2   (core_key2),
    .core_key3   (core_key3),
    .core_data   (core_data),
    .core_done   (core_done),
    .core_result (core_result)
  );

  always #5 HCLK = ~HCLK;

  typedef struct packed {
    logic [63:0] d;
    logic        enc;
    logic [63:0] k1;
    logic [63:0] k2;
    logic [63:0] k3;
  } start_t;

  start_t      st_q[$];
  logic [63:0] rd_q[$];
  bit          err_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic miss(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got event want none queued", nm);
  endtask

  // monitor
  logic   dp_v = 1'b0;
  logic   dp_w = 1'b0;
  logic   err_pend = 1'b0;
  logic   acc;
  start_t s;

  always @(negedge HCLK) begin
    if (!HRESET) begin
      dp_v     = 1'b0;
      err_pend = 1'b0;
    end else begin
      if (err_pend) begin
        chk("err_cycle2", {62'b0, bus.HRESP, bus.HREADYOUT}, 64'd3);
        err_pend = 1'b0;
      end else if (bus.HRESP && !bus.HREADYOUT) begin
        if (err_q.size() == 0) miss("unexpected_err");
        else begin
          void'(err_q.pop_front());
          err_pend = 1'b1;
        end
      end
      if (dp_v && bus.HREADYOUT) begin
        if (!dp_w && !bus.HRESP) begin
          if (rd_q.size() == 0) miss("unexpected_read");
          else chk("rdata", bus.HRDATA, rd_q.pop_front());
        end
        dp_v = 1'b0;
      end
`ifdef HTRANS_QUAL_EN
      acc = bus.HSEL & bus.HREADYOUT & bus.HTRANS[1];
`else
      acc = bus.HSEL & bus.HREADYOUT;
`endif
      if (acc) begin
        dp_v = 1'b1;
        dp_w = bus.HWRITE;
      end
      if (core_start) begin
        if (st_q.size() == 0) miss("unexpected_start");
        else begin
          s = st_q.pop_front();
          chk("start_data", core_data, s.d);
          chk("start_enc", {63'b0, core_enc}, {63'b0, s.enc});
          chk("start_key1", core_key1, s.k1);
          chk("start_key2", core_key2, s.k2);
          chk("start_key3", core_key3, s.k3);
        end
      end
    end
  end

  // bus driver (all tasks entered at posedge+1)
  logic [63:0] pend_wd = '0;

  task automatic wait_ready();
    int n = 0;
    forever begin
      @(negedge HCLK);
      if (bus.HREADY) break;
      n++;
      if (n > 50) begin
        n_cmp++;
        n_bad++;
        $display("FAIL hready_timeout: got 0 want 1");
        break;
      end
    end
    @(posedge HCLK);
    #1;
  endtask

  task automatic aphase(input logic [31:0] a, input logic w,
                        input logic [63:0] wd, input logic [2:0] sz,
                        input logic [1:0] tr);
    bus.HSEL   = 1'b1;
    bus.HADDR  = a;
    bus.HWRITE = w;
    bus.HSIZE  = sz;
    bus.HTRANS = tr;
    bus.HWDATA = pend_wd;
    wait_ready();
    pend_wd = wd;
  endtask

  task automatic wr(input int off, input logic [63:0] d);
    aphase(BASE + 32'(off), 1'b1, d, 3'b011, 2'b10);
  endtask

  task automatic rd(input int off, input logic [63:0] exp);
    rd_q.push_back(exp);
    aphase(BASE + 32'(off), 1'b0, '0, 3'b011, 2'b10);
  endtask

  task automatic idle();
    bus.HSEL   = 1'b0;
    bus.HTRANS = 2'b00;
    bus.HWRITE = 1'b0;
    bus.HWDATA = pend_wd;
    wait_ready();
    pend_wd = '0;
  endtask

  task automatic done(input logic [63:0] r);
    core_result = r;
    core_done   = 1'b1;
    @(posedge HCLK);
    #1;
    core_done = 1'b0;
  endtask

  localparam logic [63:0] K1 = 64'h1111111111111111;
  localparam logic [63:0] K2 = 64'h2222222222222222;
  localparam logic [63:0] K3 = 64'h3333333333333333;

  task automatic chk_reset_outs(input string p);
    chk({p, "_hrdata"}, bus.HRDATA, '0);
    chk({p, "_hreadyout"}, {63'b0, bus.HREADYOUT}, 64'd1);
    chk({p, "_hresp"}, {63'b0, bus.HRESP}, 64'd0);
    chk({p, "_start"}, {63'b0, core_start}, 64'd0);
    chk({p, "_enc"}, {63'b0, core_enc}, 64'd0);
    chk({p, "_key1"}, core_key1, '0);
    chk({p, "_key3"}, core_key3, '0);
    chk({p, "_data"}, core_data, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lo;
    int st;
    bus.HSEL   = 1'b0;
    bus.HADDR  = '0;
    bus.HTRANS = 2'b00;
    bus.HWRITE = 1'b0;
    bus.HSIZE  = 3'b011;
    bus.HWDATA = '0;
    #2 HRESET = 1'b0;
    #1 chk_reset_outs("rst0");
    repeat (2) @(posedge HCLK);
    #1 HRESET = 1'b1;

    // configure and launch
    wr(0, 64'd1);
    wr(1, K1);
    wr(2, K2);
    wr(3, K3);
    st_q.push_back({64'h1234567890ABCDEF, 1'b1, K1, K2, K3});
    wr(4, 64'h1234567890ABCDEF);
    rd(2, K2);
    rd(6, 64'd1);
    idle();

    // completion, result readback clears valid
    done(64'hDEADBEEFCAFEF00D);
    rd(6, 64'd2);
    rd(5, 64'hDEADBEEFCAFEF00D);
    rd(6, 64'd0);
    idle();

    // launch, mode change while busy, then stalled DATA write
    st_q.push_back({64'h7777777777777777, 1'b1, K1, K2, K3});
    wr(4, 64'h7777777777777777);
    wr(0, 64'd0);
    st_q.push_back({64'h4444444444444444, 1'b0, K1, K2, K3});
    wr(4, 64'h4444444444444444);
    lo = 0;
    st = -1;
    fork
      idle();
      begin
        repeat (9) @(posedge HCLK);
        #1 done(64'hABCDABCDABCDABCD);
      end
      begin
        for (int i = 0; i < 12; i++) begin
          @(negedge HCLK);
          if (!bus.HREADYOUT) lo++;
          if (core_start && st < 0) st = i;
        end
      end
    join
    chk("stall_cycles", 64'(lo), 64'd10);
    chk("stall_start_cycle", 64'(st), 64'd10);
    done(64'h0F0F0F0F0F0F0F0F);
    rd(5, 64'h0F0F0F0F0F0F0F0F);
    rd(6, 64'd0);
    idle();

    // error responses
    err_q.push_back(1'b1);
    aphase(BASE + 32'd5, 1'b1, 64'hBAD0BAD0BAD0BAD0, 3'b011, 2'b10);
    idle();
    rd(5, 64'h0F0F0F0F0F0F0F0F);
    idle();
    err_q.push_back(1'b1);
    aphase(BASE + 32'd1, 1'b1, 64'hFFFFFFFFFFFFFFFF, 3'b010, 2'b10);
    idle();
    rd(1, K1);
    idle();

    // HTRANS=IDLE with HSEL=1
`ifndef HTRANS_QUAL_EN
    st_q.push_back({64'h5555555555555555, 1'b0, K1, K2, K3});
`endif
    aphase(BASE + 32'd4, 1'b1, 64'h5555555555555555, 3'b011, 2'b00);
    idle();
`ifdef HTRANS_QUAL_EN
    rd(4, 64'h4444444444444444);
`else
    rd(4, 64'h5555555555555555);
`endif
    idle();

    // reset in the middle of a KEY2 read data phase
    aphase(BASE + 32'd2, 1'b0, '0, 3'b011, 2'b10);
    #2 HRESET = 1'b0;
    #1 chk_reset_outs("rst_mid");
    bus.HSEL   = 1'b0;
    bus.HTRANS = 2'b00;
    pend_wd    = '0;
    repeat (2) @(posedge HCLK);
    #1 HRESET = 1'b1;
    rd(6, 64'd0);
    rd(1, 64'd0);
    rd(0, 64'd0);
    idle();
    done(64'h9999999999999999);
    rd(6, 64'd0);
    rd(5, 64'd0);
    idle();

    repeat (5) @(posedge HCLK);
    #1;
    chk("rd_q_left", 64'(rd_q.size()), 64'd0);
    chk("st_q_left", 64'(st_q.size()), 64'd0);
    chk("err_q_left", 64'(err_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
